// File: rtl/cart_sdram_port_if.sv
// Bus bundle between the cartridge-slot requester, the byte port and the SDRAM controller.
// The slave modport is the port responder; the master modport is the requester/controller side.
interface cart_sdram_port_if;
    logic        rd;
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        ready;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        timeout;

    modport slave (
        input  rd, we, addr, din, mem_ack, mem_rdata,
        output dout, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, timeout
    );

    modport master (
        output rd, we, addr, din, mem_ack, mem_rdata,
        input  dout, ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, timeout
    );
endinterface

// File: rtl/cart_sdram_port.sv
// Cartridge-slot byte port on a 16-bit SDRAM controller, with a one-word read
// cache for zero-wait hits and a watchdog so a lost mem_ack cannot hang the CPU.
module cart_sdram_port #(
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset_n,
    cart_sdram_port_if.slave bus
);

    localparam int WDOG_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                timeout_q, timeout_d;
    logic                valid_q, valid_d;
    logic                mem_req_q, mem_req_d;

    logic                mem_we_q;
    logic [23:0]         mem_addr_q;
    logic [1:0]          mem_be_q;
    logic [15:0]         mem_wdata_q;
    logic [15:0]         cache_q;
    logic [23:0]         tag_q;

    logic                hit;
    logic                accept_wr;
    logic                accept_rd;
    logic                fill;
    logic                wr_update;

    assign hit = valid_q && (tag_q == bus.addr[24:1]);

    assign bus.ready     = (state_q == IDLE) && !bus.we && !(bus.rd && !hit);
    assign bus.dout      = hit ? (bus.addr[0] ? cache_q[15:8] : cache_q[7:0]) : 8'hFF;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.timeout   = timeout_q;

    // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        valid_d   = valid_q;
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        fill      = 1'b0;
        wr_update = 1'b0;

        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (bus.we) begin
                    accept_wr = 1'b1;
                    state_d   = WR_WAIT;
                end else if (bus.rd && !hit) begin
                    // The old word is about to be replaced; an aborted fill must not leave it looking valid.
                    accept_rd = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    if (state_q == RD_WAIT) begin
                        fill    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        wr_update = valid_q && (tag_q == mem_addr_q);
                    end
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_d = (state_d != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            mem_req_q <= mem_req_d;
        end
    end

    // NOTE: datapath and cache storage are not reset; valid_q and mem_req_q already qualify them.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= bus.addr[24:1];
            mem_be_q    <= bus.addr[0] ? 2'b10 : 2'b01;
            mem_wdata_q <= {bus.din, bus.din};
        end else if (accept_rd) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.addr[24:1];
            mem_be_q   <= 2'b11;
        end

        if (fill) begin
            cache_q <= bus.mem_rdata;
            tag_q   <= mem_addr_q;
        end else if (wr_update) begin
            if (mem_be_q[0]) cache_q[7:0]  <= mem_wdata_q[7:0];
            if (mem_be_q[1]) cache_q[15:8] <= mem_wdata_q[15:8];
        end
    end

endmodule

// File: tb/tb_cart_sdram_port.sv
// Directed bench for cart_sdram_port: reset, miss, hit, write-through, watchdog
// abort with retry, reset mid-read and simultaneous write/read.
module tb_cart_sdram_port;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    cart_sdram_port_if bus ();

    cart_sdram_port #(.TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int low_cnt;
        int req_cnt;
        logic [23:0] seen_addr;
        logic done;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.rd   = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 25'h1A5_5A5A;
        bus.din  = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;

        // Reset held for two edges
        cyc(); cyc(); #1;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_timeout", bus.timeout, 1'b0);
        check("rst_dout",    bus.dout,    8'hFF);
        bus.addr = 25'h000_0000; #1;
        check("rst_dout_a0", bus.dout,    8'hFF);
        bus.rd = 1'b0; #1;
        check("rst_ready",   bus.ready,   1'b1);
        reset_n = 1'b1;

        // Read miss at 0x0001234, ack in the third mem_req cycle
        cyc();
        bus.rd = 1'b1; bus.addr = 25'h000_1234; #1;
        low_cnt = bus.ready ? 0 : 1;
        req_cnt = 0;
        done = 1'b0;
        seen_addr = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                req_cnt++;
                if (req_cnt == 1) seen_addr = bus.mem_addr;
                if (req_cnt == 3) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = 16'hBEEF;
                end
            end
            #1;
            if (!bus.ready) low_cnt++;
            else done = 1'b1;
        end
        check("miss_done",      done,      1'b1);
        check("miss_mem_addr",  seen_addr, 24'h00091A);
        check("miss_ready_low", low_cnt,   4);
        check("miss_dout",      bus.dout,  8'hEF);
        check("miss_req_off",   bus.mem_req, 1'b0);

        // Read hit on the other byte of the same word, same cycle
        bus.addr = 25'h000_1235; #1;
        check("hit_ready", bus.ready, 1'b1);
        check("hit_dout",  bus.dout,  8'hBE);
        cyc();
        check("hit_no_req", bus.mem_req, 1'b0);

        // Write high byte of the cached word
        bus.rd = 1'b0; bus.we = 1'b1; bus.din = 8'h55; #1;
        check("wr_ready_low", bus.ready, 1'b0);
        cyc();
        bus.we = 1'b0;
        check("wr_req",   bus.mem_req,   1'b1);
        check("wr_we",    bus.mem_we,    1'b1);
        check("wr_be",    bus.mem_be,    2'b10);
        check("wr_wdata", bus.mem_wdata, 16'h5555);
        check("wr_addr",  bus.mem_addr,  24'h00091A);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        check("wr_req_off", bus.mem_req, 1'b0);
        bus.rd = 1'b1; #1;
        check("wr_hit_ready", bus.ready, 1'b1);
        check("wr_hit_dout",  bus.dout,  8'h55);
        bus.addr = 25'h000_1234; #1;
        check("wr_lo_kept",   bus.dout,  8'hEF);

        // Watchdog abort: no ack for a miss at 0x0ABCDE0
        cyc();
        bus.addr = 25'h0AB_CDE0; #1;
        check("to_ready_low", bus.ready, 1'b0);
        req_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            cyc(); #1;
            if (bus.mem_req) req_cnt++;
            else if (req_cnt > 0) done = 1'b1;
        end
        check("to_fell",      done,        1'b1);
        check("to_req_len",   req_cnt,     8);
        check("to_flag",      bus.timeout, 1'b1);
        check("to_dout",      bus.dout,    8'hFF);
        check("to_ready",     bus.ready,   1'b0);
        cyc();
        check("to_retry",     bus.mem_req, 1'b1);
        check("to_retry_we",  bus.mem_we,  1'b0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1357;
        cyc();
        bus.mem_ack = 1'b0; #1;
        check("to_fill_dout", bus.dout,    8'h57);
        check("to_sticky",    bus.timeout, 1'b1);

        // Reset while a read is outstanding; a late ack must be ignored
        bus.addr = 25'h040_0000; #1;
        cyc();
        check("rr_req_on", bus.mem_req, 1'b1);
        reset_n = 1'b0;
        cyc();
        check("rr_req_off", bus.mem_req, 1'b0);
        check("rr_timeout", bus.timeout, 1'b0);
        bus.rd = 1'b0; #1;
        check("rr_ready",   bus.ready,   1'b1);
        reset_n = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
        cyc();
        bus.mem_ack = 1'b0;
        check("rr_late_req", bus.mem_req, 1'b0);
        bus.addr = 25'h0AB_CDE0; #1;
        check("rr_valid_clr", bus.dout, 8'hFF);
        bus.addr = 25'h040_0000; #1;
        check("rr_late_dout", bus.dout, 8'hFF);

        // Simultaneous write and read at the top word
        bus.addr = 25'h1FF_FFFF; bus.din = 8'hA5; bus.we = 1'b1; bus.rd = 1'b1; #1;
        check("sim_ready", bus.ready, 1'b0);
        cyc();
        bus.we = 1'b0;
        check("sim_wr_we",    bus.mem_we,    1'b1);
        check("sim_wr_addr",  bus.mem_addr,  24'hFFFFFF);
        check("sim_wr_be",    bus.mem_be,    2'b10);
        check("sim_wr_wdata", bus.mem_wdata, 16'hA5A5);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        check("sim_gap",      bus.mem_req, 1'b0);
        check("sim_gap_rdy",  bus.ready,   1'b0);
        cyc();
        check("sim_rd_req",   bus.mem_req, 1'b1);
        check("sim_rd_we",    bus.mem_we,  1'b0);
        check("sim_rd_be",    bus.mem_be,  2'b11);
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA533;
        cyc();
        bus.mem_ack = 1'b0; #1;
        check("sim_rd_ready", bus.ready, 1'b1);
        check("sim_rd_dout",  bus.dout,  8'hA5);
        bus.rd = 1'b0; bus.addr = 25'h000_0001; #1;
        check("no_alias",     bus.dout,  8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
